// File: rtl/lsu_axil_pkg.sv
// Shared types and constants for the LSU-to-AXI4-Lite bridge.
// Response codes, FSM encoding and the default protection attribute.
package lsu_axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } lsu_axil_state_t;

    localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

    function automatic logic resp_is_err(input axil_resp_t r);
        return r != OKAY;
    endfunction

endpackage

// File: rtl/lsu_axil_bridge.sv
// Serializing AXI4-Lite master for LSU accesses outside the DMEM window.
// One request is captured, one AXI transaction runs, one completion pulses.
module lsu_axil_bridge
    import lsu_axil_pkg::*;
#(
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        rready_lsu,
    output logic        rvalid_lsu,
    input  logic        wvalid_lsu,
    output logic        wready_lsu,
    input  logic [3:0]  strb_lsu,
    input  logic [31:0] addr_lsu,
    input  logic [31:0] data_lsu_i,
    output logic [31:0] data_lsu_o,
    output logic        err_lsu,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    lsu_axil_state_t state_q, state_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic [31:0] rdata_q;
    axil_resp_t  resp_q;
    logic        is_wr_q;
    logic        aw_done_q;
    logic        w_done_q;

    logic aw_hs;
    logic w_hs;
    logic aw_ok;
    logic w_ok;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign aw_ok = aw_done_q || aw_hs;
    assign w_ok  = w_done_q || w_hs;

    // Payload comes only from captured registers so it is stable under VALID.
    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = strb_q;
    assign awprot = AXIL_PROT_DEFAULT;
    assign arprot = AXIL_PROT_DEFAULT;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            resp_q    <= OKAY;
            is_wr_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (wvalid_lsu) begin
                        addr_q  <= addr_lsu;
                        wdata_q <= data_lsu_i;
                        strb_q  <= strb_lsu;
                        is_wr_q <= 1'b1;
                    end else if (rready_lsu) begin
                        addr_q  <= addr_lsu;
                        is_wr_q <= 1'b0;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                end
                WR_RESP: begin
                    if (bvalid) resp_q <= axil_resp_t'(bresp);
                end
                RD_RESP: begin
                    if (rvalid) begin
                        rdata_q <= rdata;
                        resp_q  <= axil_resp_t'(rresp);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    wvalid_lsu:                state_d = WR_REQ;
                    !wvalid_lsu && rready_lsu: state_d = RD_REQ;
                    default:                   state_d = IDLE;
                endcase
            end
            WR_REQ:  if (aw_ok && w_ok) state_d = WR_RESP;
            WR_RESP: if (bvalid)        state_d = DONE;
            RD_REQ:  if (arready)       state_d = RD_RESP;
            RD_RESP: if (rvalid)        state_d = DONE;
            DONE:                       state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        rvalid_lsu = 1'b0;
        wready_lsu = 1'b0;
        err_lsu    = 1'b0;
        data_lsu_o = '0;
        unique case (state_q)
            WR_REQ: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
            end
            WR_RESP: bready  = 1'b1;
            RD_REQ:  arvalid = 1'b1;
            RD_RESP: rready  = 1'b1;
            DONE: begin
                wready_lsu = is_wr_q;
                rvalid_lsu = !is_wr_q;
                err_lsu    = resp_is_err(resp_q);
                if (!is_wr_q) begin
                    data_lsu_o = resp_is_err(resp_q) ? ERR_RDATA : rdata_q;
                end
            end
            default: ;
        endcase
    end

endmodule
